// File: rtl/cent_input_pkg.sv
// Shared constants for the Centipede player-input conditioner: bus bit positions,
// the all-inactive bus value and the coin state machine encoding.
package cent_input_pkg;

    localparam int PI_COIN_R    = 9;
    localparam int PI_COIN_C    = 8;
    localparam int PI_COIN_L    = 7;
    localparam int PI_SELF_TEST = 6;
    localparam int PI_COCKTAIL  = 5;
    localparam int PI_SLAM      = 4;
    localparam int PI_START1    = 3;
    localparam int PI_START2    = 2;
    localparam int PI_FIRE2     = 1;
    localparam int PI_FIRE1     = 0;

    // Every control released; cocktail is the only active-high bit, so it sits at 0.
    localparam logic [9:0] PI_IDLE = 10'h3DF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_e;

endpackage

// File: rtl/cent_debounce.sv
// One button: two-flop synchronizer followed by a counter that only lets the
// stable level change after DEBOUNCE_CYCLES consecutive disagreeing samples.
module cent_debounce
    import cent_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk12m,
    input  logic reset,
    input  logic btn_raw_i,
    output logic stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk12m) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/cent_input_cond.sv
// Conditions raw buttons into the Centipede playerinput bus with a one-shot coin pulse.
// Define CENT_AUTO_PLAY_EN to synchronize and merge the auto_*_n auto-play inputs.
module cent_input_cond
    import cent_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int COIN_PULSE_CYCLES = 600000
) (
    input  logic       clk12m,
    input  logic       reset,
    input  logic [2:0] btn_i,
    input  logic       auto_coin_n,
    input  logic       auto_start_n,
    input  logic       auto_throw_n,
    output logic [9:0] playerinput_o,
    output logic [7:0] coin_count_o,
    output logic       coin_busy_o
);

    localparam int PCW = $clog2(COIN_PULSE_CYCLES + 1);

    logic [2:0] stable;

    for (genvar i = 0; i < 3; i++) begin : g_db
        cent_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk12m   (clk12m),
            .reset    (reset),
            .btn_raw_i(btn_i[i]),
            .stable_o (stable[i])
        );
    end

    logic auto_start, auto_throw, auto_coin_fall, auto_coin_idle;

`ifdef CENT_AUTO_PLAY_EN
    logic [2:0] auto_s1_q, auto_s1_d;
    logic [2:0] auto_s2_q, auto_s2_d;
    logic       auto_coin_prev_q, auto_coin_prev_d;

    always_comb begin
        auto_s1_d        = {auto_throw_n, auto_start_n, auto_coin_n};
        auto_s2_d        = auto_s1_q;
        auto_coin_prev_d = auto_s2_q[0];
    end

    // Auto inputs are active-low, so their synchronizers rest at 1 to avoid a phantom press.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            auto_s1_q        <= '1;
            auto_s2_q        <= '1;
            auto_coin_prev_q <= 1'b1;
        end else begin
            auto_s1_q        <= auto_s1_d;
            auto_s2_q        <= auto_s2_d;
            auto_coin_prev_q <= auto_coin_prev_d;
        end
    end

    assign auto_start     = ~auto_s2_q[1];
    assign auto_throw     = ~auto_s2_q[2];
    assign auto_coin_fall = auto_coin_prev_q & ~auto_s2_q[0];
    assign auto_coin_idle = auto_s2_q[0];
`else
    logic unused_auto;
    assign unused_auto    = &{1'b0, auto_coin_n, auto_start_n, auto_throw_n};
    assign auto_start     = 1'b0;
    assign auto_throw     = 1'b0;
    assign auto_coin_fall = 1'b0;
    assign auto_coin_idle = 1'b1;
`endif

    coin_state_e    state_q, state_d;
    logic [PCW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]     coin_count_q, coin_count_d;
    logic           coin_prev_q, coin_prev_d;
    logic           coin_busy_q, coin_busy_d;
    logic [9:0]     playerinput_q, playerinput_d;
    logic           coin_trigger;

    always_comb begin
        coin_trigger = (stable[0] & ~coin_prev_q) | auto_coin_fall;
        coin_prev_d  = stable[0];
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        coin_count_d = coin_count_q;
        unique case (state_q)
            IDLE: begin
                if (coin_trigger) begin
                    state_d      = PULSE;
                    pulse_cnt_d  = '0;
                    coin_count_d = coin_count_q + 8'd1;
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PCW'(COIN_PULSE_CYCLES - 1)) begin
                    state_d = HOLD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PCW'(1);
                end
            end
            HOLD: begin
                if (!stable[0] && auto_coin_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so coin_l low spans exactly the PULSE residency.
        coin_busy_d              = (state_d != IDLE);
        playerinput_d            = PI_IDLE;
        playerinput_d[PI_START1] = ~(stable[1] | auto_start);
        playerinput_d[PI_FIRE1]  = ~(stable[2] | auto_throw);
        playerinput_d[PI_COIN_L] = (state_d != PULSE);
    end

    always_ff @(posedge clk12m) begin
        if (reset) begin
            state_q       <= IDLE;
            pulse_cnt_q   <= '0;
            coin_count_q  <= '0;
            coin_prev_q   <= 1'b0;
            coin_busy_q   <= 1'b0;
            playerinput_q <= PI_IDLE;
        end else begin
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            coin_count_q  <= coin_count_d;
            coin_prev_q   <= coin_prev_d;
            coin_busy_q   <= coin_busy_d;
            playerinput_q <= playerinput_d;
        end
    end

    assign playerinput_o = playerinput_q;
    assign coin_count_o  = coin_count_q;
    assign coin_busy_o   = coin_busy_q;

endmodule

// File: tb/tb_cent_input_cond.sv
// Self-checking bench for cent_input_cond with DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=8.
// Auto-play checks are included when CENT_AUTO_PLAY_EN is defined for the build.
module tb_cent_input_cond;
    import cent_input_pkg::*;

    localparam int DB = 4;
    localparam int CP = 8;

    logic       clk12m = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_i = 3'b000;
    logic       auto_coin_n = 1'b1;
    logic       auto_start_n = 1'b1;
    logic       auto_throw_n = 1'b1;
    logic [9:0] playerinput_o;
    logic [7:0] coin_count_o;
    logic       coin_busy_o;

    int check_count = 0;
    int pass_count = 0;
    int exp_count = 0;

    always #5 clk12m = ~clk12m;

    cent_input_cond #(
        .DEBOUNCE_CYCLES  (DB),
        .COIN_PULSE_CYCLES(CP)
    ) dut (
        .clk12m       (clk12m),
        .reset        (reset),
        .btn_i        (btn_i),
        .auto_coin_n  (auto_coin_n),
        .auto_start_n (auto_start_n),
        .auto_throw_n (auto_throw_n),
        .playerinput_o(playerinput_o),
        .coin_count_o (coin_count_o),
        .coin_busy_o  (coin_busy_o)
    );

    task automatic tick();
        @(posedge clk12m);
        @(negedge clk12m);
    endtask

    // Runs n cycles and reports how many coin_l samples were low and how many low runs began.
    task automatic watch_coin(input int n, output int lows, output int runs);
        logic prev;
        lows = 0;
        runs = 0;
        prev = playerinput_o[PI_COIN_L];
        for (int i = 0; i < n; i++) begin
            tick();
            if (playerinput_o[PI_COIN_L] === 1'b0) lows++;
            if (prev === 1'b1 && playerinput_o[PI_COIN_L] === 1'b0) runs++;
            prev = playerinput_o[PI_COIN_L];
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (coin_busy_o !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check_count++;
        if (coin_busy_o !== 1'b0) $display("[TB] FAIL %s_idle_timeout: busy=%b required 0", name, coin_busy_o);
        else pass_count++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_count++;
        if (playerinput_o !== PI_IDLE) $display("[TB] FAIL reset_pi: got %h required %h", playerinput_o, PI_IDLE);
        else pass_count++;
        check_count++;
        if (coin_count_o !== 8'd0) $display("[TB] FAIL reset_count: got %0d required 0", coin_count_o);
        else pass_count++;
        check_count++;
        if (coin_busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", coin_busy_o);
        else pass_count++;
        reset = 1'b0;
        repeat (8) tick();
        check_count++;
        if (playerinput_o !== PI_IDLE) $display("[TB] FAIL post_reset_pi: got %h required %h", playerinput_o, PI_IDLE);
        else pass_count++;
        check_count++;
        if (coin_busy_o !== 1'b0) $display("[TB] FAIL post_reset_busy: got %b required 0", coin_busy_o);
        else pass_count++;
    endtask

    task automatic test_fire_latency();
        logic exp_bit;
        btn_i[2] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_bit = (e >= DB + 3) ? 1'b0 : 1'b1;
            check_count++;
            if (playerinput_o[PI_FIRE1] !== exp_bit)
                $display("[TB] FAIL fire_press_edge%0d: got %b required %b", e, playerinput_o[PI_FIRE1], exp_bit);
            else pass_count++;
        end
        btn_i[2] = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_bit = (e >= DB + 3) ? 1'b1 : 1'b0;
            check_count++;
            if (playerinput_o[PI_FIRE1] !== exp_bit)
                $display("[TB] FAIL fire_release_edge%0d: got %b required %b", e, playerinput_o[PI_FIRE1], exp_bit);
            else pass_count++;
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                btn_i[1] = (c < 3);
                tick();
                check_count++;
                if (playerinput_o[PI_START1] !== 1'b1)
                    $display("[TB] FAIL glitch_start1_r%0d_c%0d: got %b required 1", r, c, playerinput_o[PI_START1]);
                else pass_count++;
            end
        end
        btn_i[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_count++;
            if (playerinput_o[PI_START1] !== 1'b1)
                $display("[TB] FAIL glitch_tail_c%0d: got %b required 1", c, playerinput_o[PI_START1]);
            else pass_count++;
        end
    endtask

    task automatic test_coin_hold();
        int lows, runs;
        btn_i[0] = 1'b1;
        watch_coin(50, lows, runs);
        exp_count = (exp_count + 1) % 256;
        check_count++;
        if (lows !== CP) $display("[TB] FAIL coin_hold_width: got %0d low cycles required %0d", lows, CP);
        else pass_count++;
        check_count++;
        if (runs !== 1) $display("[TB] FAIL coin_hold_runs: got %0d pulses required 1", runs);
        else pass_count++;
        check_count++;
        if (coin_count_o !== 8'(exp_count)) $display("[TB] FAIL coin_hold_count: got %0d required %0d", coin_count_o, exp_count);
        else pass_count++;
        check_count++;
        if (coin_busy_o !== 1'b1) $display("[TB] FAIL coin_hold_busy: got %b required 1", coin_busy_o);
        else pass_count++;
        btn_i[0] = 1'b0;
        for (int e = 1; e <= DB + 2; e++) begin
            tick();
            check_count++;
            if (coin_busy_o !== 1'b1) $display("[TB] FAIL coin_busy_early_edge%0d: got %b required 1", e, coin_busy_o);
            else pass_count++;
        end
        wait_idle("coin_hold");
    endtask

    task automatic test_coin_wrap();
        bit saw_zero;
        saw_zero = 1'b0;
        for (int i = 0; i < 256; i++) begin
            btn_i[0] = 1'b1;
            repeat (DB + 4) tick();
            btn_i[0] = 1'b0;
            wait_idle("coin_wrap");
            exp_count = (exp_count + 1) % 256;
            check_count++;
            if (coin_count_o !== 8'(exp_count))
                $display("[TB] FAIL coin_wrap_press%0d: got %0d required %0d", i, coin_count_o, exp_count);
            else pass_count++;
            if (coin_count_o === 8'd0) saw_zero = 1'b1;
        end
        check_count++;
        if (saw_zero !== 1'b1) $display("[TB] FAIL coin_wrap_zero: seen %b required 1", saw_zero);
        else pass_count++;
    endtask

    task automatic test_simultaneous();
        int lows, runs;
        btn_i[0] = 1'b1;
        repeat (4) tick();
        auto_coin_n = 1'b0;
        watch_coin(30, lows, runs);
        exp_count = (exp_count + 1) % 256;
        check_count++;
        if (runs !== 1) $display("[TB] FAIL simul_runs: got %0d pulses required 1", runs);
        else pass_count++;
        check_count++;
        if (lows !== CP) $display("[TB] FAIL simul_width: got %0d required %0d", lows, CP);
        else pass_count++;
        check_count++;
        if (coin_count_o !== 8'(exp_count)) $display("[TB] FAIL simul_count: got %0d required %0d", coin_count_o, exp_count);
        else pass_count++;
        btn_i[0] = 1'b0;
        auto_coin_n = 1'b1;
        wait_idle("simul");
        watch_coin(20, lows, runs);
        check_count++;
        if (runs !== 0) $display("[TB] FAIL simul_extra: got %0d extra pulses required 0", runs);
        else pass_count++;
    endtask

    task automatic test_reset_mid_pulse();
        int n, lows, runs;
        btn_i[0] = 1'b1;
        n = 0;
        while (playerinput_o[PI_COIN_L] !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        check_count++;
        if (playerinput_o[PI_COIN_L] !== 1'b0) $display("[TB] FAIL midreset_pulse_start: coin_l=%b required 0", playerinput_o[PI_COIN_L]);
        else pass_count++;
        repeat (3) tick();
        reset = 1'b1;
        btn_i[0] = 1'b0;
        tick();
        check_count++;
        if (playerinput_o !== PI_IDLE) $display("[TB] FAIL midreset_pi: got %h required %h", playerinput_o, PI_IDLE);
        else pass_count++;
        check_count++;
        if (coin_busy_o !== 1'b0) $display("[TB] FAIL midreset_busy: got %b required 0", coin_busy_o);
        else pass_count++;
        reset = 1'b0;
        exp_count = 0;
        repeat (10) tick();
        btn_i[0] = 1'b1;
        watch_coin(12, lows, runs);
        btn_i[0] = 1'b0;
        begin
            int l2, r2;
            watch_coin(28, l2, r2);
            lows += l2;
            runs += r2;
        end
        exp_count = 1;
        check_count++;
        if (lows !== CP) $display("[TB] FAIL midreset_fresh_width: got %0d required %0d", lows, CP);
        else pass_count++;
        check_count++;
        if (runs !== 1) $display("[TB] FAIL midreset_fresh_runs: got %0d required 1", runs);
        else pass_count++;
        check_count++;
        if (coin_count_o !== 8'(exp_count)) $display("[TB] FAIL midreset_fresh_count: got %0d required %0d", coin_count_o, exp_count);
        else pass_count++;
        wait_idle("midreset");
    endtask

`ifdef CENT_AUTO_PLAY_EN
    task automatic test_auto_throw();
        logic exp_bit;
        auto_throw_n = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_bit = (e >= 3) ? 1'b0 : 1'b1;
            check_count++;
            if (playerinput_o[PI_FIRE1] !== exp_bit)
                $display("[TB] FAIL auto_throw_edge%0d: got %b required %b", e, playerinput_o[PI_FIRE1], exp_bit);
            else pass_count++;
        end
        auto_throw_n = 1'b1;
        repeat (4) tick();
        check_count++;
        if (playerinput_o[PI_FIRE1] !== 1'b1) $display("[TB] FAIL auto_throw_release: got %b required 1", playerinput_o[PI_FIRE1]);
        else pass_count++;
    endtask
`endif

    // Reference: the debounced level flips once the four most recent samples the
    // debouncer has seen (raw delayed by two synchronizer stages) all disagree with it.
    task automatic test_random_fire();
        bit   hist[$];
        bit   st, cur, exp_bit;
        int   run_left, n;
        st = 1'b0;
        cur = 1'b0;
        run_left = 0;
        repeat (6) hist.push_back(1'b0);
        for (int c = 0; c < 400; c++) begin
            if (run_left == 0) begin
                cur = ~cur;
                run_left = $urandom_range(1, 8);
            end
            run_left--;
            btn_i[2] = cur;
            hist.push_back(cur);
            @(posedge clk12m);
            exp_bit = ~st;
            n = hist.size();
            if (hist[n-3] != st && hist[n-4] != st && hist[n-5] != st && hist[n-6] != st) st = ~st;
            @(negedge clk12m);
            check_count++;
            if (playerinput_o[PI_FIRE1] !== exp_bit)
                $display("[TB] FAIL random_fire_c%0d: got %b required %b", c, playerinput_o[PI_FIRE1], exp_bit);
            else pass_count++;
        end
        btn_i[2] = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk12m);
        test_reset();
        test_fire_latency();
        test_glitch();
        test_coin_hold();
        test_coin_wrap();
        test_simultaneous();
        test_reset_mid_pulse();
`ifdef CENT_AUTO_PLAY_EN
        test_auto_throw();
`endif
        test_random_fire();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
